div_sequencer: RTL and testbench

// Multi-cycle iterative divider with its sequencing FSM, for DIV/DIVU in the EX stage.
// On a request it freezes the pipeline by driving a stall to the hazard unit.
// It runs a radix-2 restoring division of WIDTH iterations, then writes quotient to LO and remainder to HI.
// It delivers both through a one-cycle HI/LO write strobe aimed at hilo_reg.

---
 rtl/div_sequencer_if.sv | 26 ++
 rtl/div_sequencer.sv | 142 ++++++++++++++
 tb/tb_div_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the EX-stage divide sequencer and its
// surrounding pipeline logic (hazard unit, HI/LO register).
interface div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_startE;
  logic             i_signedE;
  logic             i_annulE;
  logic [WIDTH-1:0] i_srcaE;
  logic [WIDTH-1:0] i_srcbE;
  logic             o_stallE;
  logic             o_busy;
  logic             o_hilo_we;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_startE, i_signedE, i_annulE, i_srcaE, i_srcbE,
    input  o_stallE, o_busy, o_hilo_we, o_hi, o_lo
  );

  modport slave (
    input  i_startE, i_signedE, i_annulE, i_srcaE, i_srcbE,
    output o_stallE, o_busy, o_hilo_we, o_hi, o_lo
  );
endinterface

// File: rtl/div_sequencer.sv
// Iterative radix-2 restoring divider for DIV/DIVU: stalls the pipeline while
// it runs, then strobes quotient (LO) and remainder (HI) out for one cycle.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  div_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rawA;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_qNeg;
  logic             r_rNeg;
  logic             r_divZero;

  logic             w_aNeg;
  logic             w_bNeg;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_resLo;
  logic [WIDTH-1:0] w_resHi;
  logic             w_stall;
  logic             w_we;

  assign w_aNeg  = bus.i_signedE & bus.i_srcaE[WIDTH-1];
  assign w_bNeg  = bus.i_signedE & bus.i_srcbE[WIDTH-1];
  assign w_absA  = w_aNeg ? -bus.i_srcaE : bus.i_srcaE;
  assign w_absB  = w_bNeg ? -bus.i_srcbE : bus.i_srcbE;

  // The next dividend bit enters the partial remainder; trial bit WIDTH is the borrow.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_div};

  always_comb begin
    w_resLo = r_qNeg ? -r_quo : r_quo;
    w_resHi = r_rNeg ? -r_rem : r_rem;
    if (r_divZero) begin
      w_resLo = '1;
      w_resHi = r_rawA;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_startE) begin
          w_next  = PREP;
          w_stall = 1'b1;
        end
      end
      PREP: begin
        w_stall = 1'b1;
        w_next  = (w_absB == '0) ? DONE : RUN;
      end
      RUN: begin
        w_stall = 1'b1;
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        w_we   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // A flush wins over everything, including a completing division.
    if (bus.i_annulE) begin
      w_next  = IDLE;
      w_stall = 1'b0;
      w_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_rawA    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_qNeg    <= 1'b0;
      r_rNeg    <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        PREP: begin
          r_quo     <= w_absA;
          r_rem     <= '0;
          r_div     <= w_absB;
          r_rawA    <= bus.i_srcaE;
          r_qNeg    <= w_aNeg ^ w_bNeg;
          r_rNeg    <= w_aNeg;
          r_divZero <= (bus.i_srcbE == '0);
          r_cnt     <= '0;
        end
        RUN: begin
          if (!w_trial[WIDTH]) begin
            r_rem <= w_trial[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
      if (w_we) begin
        r_hi <= w_resHi;
        r_lo <= w_resLo;
      end
    end
  end

  assign bus.o_stallE  = w_stall;
  assign bus.o_busy    = (r_state != IDLE);
  assign bus.o_hilo_we = w_we;
  assign bus.o_hi      = w_we ? w_resHi : r_hi;
  assign bus.o_lo      = w_we ? w_resLo : r_lo;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, hand-built
// annul/reset sequences and randomized divisions against an arithmetic model.
module tb_div_sequencer;

  localparam int WIDTH   = 32;
  localparam int LATENCY = WIDTH + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] lastLo = '0;
  logic [31:0] lastHi = '0;

  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(WIDTH)) bus ();

  div_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
    int          expCycles;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic sgn, input logic annul,
                               input logic [31:0] a, input logic [31:0] b);
    bus.i_startE  = start;
    bus.i_signedE = sgn;
    bus.i_annulE  = annul;
    bus.i_srcaE   = a;
    bus.i_srcbE   = b;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void refModel(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Holds startE from cycle 0 until the strobe appears; optionally scrambles operands after PREP.
  task automatic runDiv(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit scramble,
                        input logic [31:0] expLo, input logic [31:0] expHi,
                        input int expCycles);
    int          cyc     = 0;
    int          stalls  = 0;
    int          doneCyc = -1;
    logic [31:0] lo      = '0;
    logic [31:0] hi      = '0;
    logic [31:0] ca      = a;
    logic [31:0] cb      = b;
    while (doneCyc < 0 && cyc < 100) begin
      if (scramble && cyc >= 2) begin
        ca = $urandom;
        cb = $urandom;
      end
      applyStimulus(1'b1, sgn, 1'b0, ca, cb);
      if (cyc == 0) begin
        checkOutput({tag, " busy at start"}, 32'(bus.o_busy), 32'd0);
        checkOutput({tag, " no strobe at start"}, 32'(bus.o_hilo_we), 32'd0);
      end
      if (bus.o_stallE) stalls++;
      if (bus.o_hilo_we) begin
        doneCyc = cyc;
        lo      = bus.o_lo;
        hi      = bus.o_hi;
      end
      nextCycle();
      cyc++;
    end
    checkOutput({tag, " done cycle"}, 32'(doneCyc), 32'(expCycles));
    checkOutput({tag, " stall cycles"}, 32'(stalls), 32'(expCycles));
    checkOutput({tag, " lo"}, lo, expLo);
    checkOutput({tag, " hi"}, hi, expHi);
    lastLo = expLo;
    lastHi = expHi;
  endtask

  initial begin
    logic        rs;
    logic [31:0] ra, rb, rLo, rHi;

    vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          LATENCY};
    vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  LATENCY};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          LATENCY};
    vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          LATENCY};
    vecs[4] = '{1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  2};
    vecs[5] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          LATENCY};
    vecs[6] = '{1'b0, 32'd10,         32'd3,          32'd3,          32'd1,          LATENCY};
    vecs[7] = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000,  2};
    vecs[8] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          LATENCY};

    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    nextCycle();
    checkOutput("reset stallE", 32'(bus.o_stallE), 32'd0);
    checkOutput("reset busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset hilo_we", 32'(bus.o_hilo_we), 32'd0);
    checkOutput("reset hi", bus.o_hi, 32'd0);
    checkOutput("reset lo", bus.o_lo, 32'd0);
    rst = 1'b1;
    nextCycle();

    // Back-to-back: each start is raised the cycle right after the previous DONE.
    for (int i = 0; i < 9; i++) begin
      runDiv($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0,
             vecs[i].expLo, vecs[i].expHi, vecs[i].expCycles);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("no restart after DONE", 32'(bus.o_busy), 32'd0);
    checkOutput("results held lo", bus.o_lo, lastLo);
    nextCycle();

    // Annul during RUN at cycle 10, fresh start at cycle 12.
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FF9C, 32'd7);
    checkOutput("annul stallE", 32'(bus.o_stallE), 32'd0);
    checkOutput("annul hilo_we", 32'(bus.o_hilo_we), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("annul idle", 32'(bus.o_busy), 32'd0);
    checkOutput("annul hi kept", bus.o_hi, lastHi);
    checkOutput("annul lo kept", bus.o_lo, lastLo);
    nextCycle();
    runDiv("after annul", 1'b0, 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, LATENCY);

    // Annul coinciding with DONE must suppress the strobe and the HI/LO update.
    for (int c = 0; c < LATENCY; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd50, 32'd5);
      nextCycle();
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd50, 32'd5);
    checkOutput("annul at done hilo_we", 32'(bus.o_hilo_we), 32'd0);
    checkOutput("annul at done lo", bus.o_lo, lastLo);
    checkOutput("annul at done hi", bus.o_hi, lastHi);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("annul at done idle", 32'(bus.o_busy), 32'd0);
    checkOutput("annul at done lo held", bus.o_lo, lastLo);
    nextCycle();

    // Synchronous reset pulse at cycle 20 of a running division.
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd12345, 32'd67);
      nextCycle();
    end
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd12345, 32'd67);
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("midreset stallE", 32'(bus.o_stallE), 32'd0);
    checkOutput("midreset busy", 32'(bus.o_busy), 32'd0);
    checkOutput("midreset hilo_we", 32'(bus.o_hilo_we), 32'd0);
    checkOutput("midreset hi", bus.o_hi, 32'd0);
    checkOutput("midreset lo", bus.o_lo, 32'd0);
    runDiv("after reset", 1'b0, 32'd12345, 32'd67, 1'b0, 32'd184, 32'd17, LATENCY);

    // Random divisions with operands disturbed after PREP.
    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -(32'($urandom_range(1, 15)));
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      refModel(rs, ra, rb, rLo, rHi);
      runDiv($sformatf("rand%0d", n), rs, ra, rb, 1'b1, rLo, rHi,
             (rb == 32'd0) ? 2 : LATENCY);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    nextCycle();
    checkOutput("final idle", 32'(bus.o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
